// File: rtl/fb_pkg.sv
// fb_pkg: constants, state encoding and address helper shared by the
// framebuffer write-side controller.
//   H_RES / V_RES    visible raster size; H_RES is also the row stride
//   FB_DEPTH         number of framebuffer words (H_RES*V_RES)
//   ADDR_W           framebuffer address width (FB_DEPTH <= 2**ADDR_W)
//   CLEAR_COLOR      colour written by the clear sweep
//   fb_wstate_t      write-controller state encoding
//   fb_addr()        linear address row*H_RES+col for the default raster
package fb_pkg;

    localparam int unsigned H_RES       = 640;
    localparam int unsigned V_RES       = 480;
    localparam int unsigned FB_DEPTH    = H_RES * V_RES;
    localparam int unsigned ADDR_W      = 19;
    localparam int unsigned ROW_W       = 9;
    localparam int unsigned COL_W       = 10;
    localparam logic [3:0]  CLEAR_COLOR = 4'h0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        DRAW    = 2'd2,
        WAIT_VB = 2'd3
    } fb_wstate_t;

    // For a 640-pixel stride the multiply collapses to row*512 + row*128.
    // Widening before the shifts keeps every in-range result exact.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
        logic [ADDR_W-1:0] r;
        logic [ADDR_W-1:0] c;
        r = ADDR_W'(row);
        c = ADDR_W'(col);
        if (H_RES == 640)
            return (r << 9) + (r << 7) + c;
        else
            return ADDR_W'(H_RES * 32'(row) + 32'(col));
    endfunction

endpackage

// File: rtl/fb_write_ctrl_clear_seq.sv
// fb_clear_seq: address counter for the framebuffer clear sweep.
//   clk, rst   clock; asynchronous active-low reset
//   start      reload the counter to address 0 (wins over en)
//   en         advance one address per cycle
//   cnt        current sweep address
//   last       cnt is the final framebuffer address
// The counter saturates on the last address instead of wrapping, so a
// stalled sweep can never re-issue address 0 on its own.
module fb_clear_seq
    import fb_pkg::*;
#(
    parameter int unsigned CNT_W = fb_pkg::ADDR_W,
    parameter int unsigned DEPTH = fb_pkg::FB_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last = (cnt_q == LAST_ADDR);
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (start)
            cnt_d = '0;
        else if (en && !last)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/fb_write_ctrl.sv
// fb_write_ctrl: write-side controller for framebuffer port A.
// Each frame clears the whole buffer, then hands the write port to the
// vector pixel stream, and finally commits the frame on vertical blank.
//   clk, rst        clock; asynchronous active-low reset
//   frame_start     pulse: begin a new frame (aborts any frame in flight)
//   frame_end       pulse: pixel source has finished the frame
//   vblank          display vertical-blank level
//   pix_valid/ready pixel handshake; pix_row/pix_col/pix_color payload
//   w_addr/en_w/color_out  registered framebuffer write port
//   clearing        high while the clear sweep runs
//   frame_done      one-cycle commit pulse towards the display side
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no frame active, write port quiet
// CLEAR   | sweeping CLEAR_COLOR over every address, one per cycle
// DRAW    | accepting pixels from the vector stream
// WAIT_VB | frame finished, waiting for vblank to commit it
module fb_write_ctrl
    import fb_pkg::*;
#(
    parameter int unsigned H_RES       = fb_pkg::H_RES,
    parameter int unsigned V_RES       = fb_pkg::V_RES,
    parameter int unsigned ADDR_W      = fb_pkg::ADDR_W,
    parameter logic [3:0]  CLEAR_COLOR = fb_pkg::CLEAR_COLOR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              vblank,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [8:0]        pix_row,
    input  logic [9:0]        pix_col,
    input  logic [3:0]        pix_color,
    output logic [ADDR_W-1:0] w_addr,
    output logic              en_w,
    output logic [3:0]        color_out,
    output logic              clearing,
    output logic              frame_done
);

    localparam int unsigned DEPTH = H_RES * V_RES;

    fb_wstate_t        state_q, state_d;
    logic              end_pending_q, end_pending_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic              en_w_q, en_w_d;
    logic [3:0]        color_q, color_d;

    logic              clr_start;
    logic              clr_en;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_last;

    logic              pix_accept;
    logic              pix_in_range;
    logic [ADDR_W-1:0] pix_addr;

    fb_clear_seq #(
        .CNT_W (ADDR_W),
        .DEPTH (DEPTH)
    ) u_clear_seq (
        .clk   (clk),
        .rst   (rst),
        .start (clr_start),
        .en    (clr_en),
        .cnt   (clr_cnt),
        .last  (clr_last)
    );

    generate
        if (H_RES == fb_pkg::H_RES) begin : g_addr_pkg
            assign pix_addr = ADDR_W'(fb_addr(pix_row, pix_col));
        end else begin : g_addr_generic
            assign pix_addr = ADDR_W'(H_RES * 32'(pix_row) + 32'(pix_col));
        end
    endgenerate

    assign pix_in_range = (32'(pix_row) < V_RES) && (32'(pix_col) < H_RES);

    // A frame_end seen during CLEAR means DRAW must leave on its first
    // cycle, so the stream is not offered the port at all in that case.
    assign pix_ready  = (state_q == DRAW) && !end_pending_q;
    assign pix_accept = pix_valid && pix_ready;

    assign clearing   = (state_q == CLEAR);
    // A restart arriving together with vblank kills the commit.
    assign frame_done = (state_q == WAIT_VB) && vblank && !frame_start;

    assign w_addr    = w_addr_q;
    assign en_w      = en_w_q;
    assign color_out = color_q;

    always_comb begin
        state_d       = state_q;
        end_pending_d = end_pending_q;
        en_w_d        = 1'b0;
        w_addr_d      = w_addr_q;
        color_d       = color_q;
        clr_start     = 1'b0;
        clr_en        = 1'b0;

        if (frame_start) begin
            // Restart from any state; a pixel handshaked this cycle is dropped.
            state_d       = CLEAR;
            end_pending_d = 1'b0;
            clr_start     = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                CLEAR: begin
                    clr_en   = 1'b1;
                    en_w_d   = 1'b1;
                    w_addr_d = clr_cnt;
                    color_d  = CLEAR_COLOR;
                    if (frame_end)
                        end_pending_d = 1'b1;
                    if (clr_last)
                        state_d = DRAW;
                end
                DRAW: begin
                    if (pix_accept && pix_in_range) begin
                        en_w_d   = 1'b1;
                        w_addr_d = pix_addr;
                        color_d  = pix_color;
                    end
                    if (frame_end || end_pending_q) begin
                        state_d       = WAIT_VB;
                        end_pending_d = 1'b0;
                    end
                end
                WAIT_VB: begin
                    if (vblank)
                        state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            end_pending_q <= 1'b0;
            w_addr_q      <= '0;
            en_w_q        <= 1'b0;
            color_q       <= 4'h0;
        end else begin
            state_q       <= state_d;
            end_pending_q <= end_pending_d;
            w_addr_q      <= w_addr_d;
            en_w_q        <= en_w_d;
            color_q       <= color_d;
        end
    end

endmodule
